usb_ep_out_fill_ctrl: RTL and testbench
=======================================

// Module: usb_ep_out_fill_ctrl
// PURPOSE
//  Feeds one OUT endpoint's transactional FIFO fill interface (EP_OUT_fill*, EP_OUT_dataValid/data, EP_OUT_full) from the
//  RX packet decoder. Checks the data toggle, detects FIFO full and over-length packets, commits or rolls back each packet,
//  and returns the handshake (ACK/NAK/none) to the protocol engine. Sits between RX decoder and endpoint FIFO.
// PARAMETERS
//  MAX_PACKET_SIZE  64  max payload bytes per DATAx packet; more = babble
//  TIMEOUT_CYCLES   24  clk12 cycles allowed from OUT token to DATAx start (needs USB_EP_OUT_FILL_TIMEOUT_EN)
//  IS_ISOCHRONOUS   0   1: toggle ignored, respValid_o never asserted
// PORTS
//  clk12_i                     in   1  12 MHz clock
//  rst_i                       in   1  asynchronous, active-high reset
//  gotTransStartPacket_i       in   1  1-cycle pulse: OUT token addressed to this EP
//  resetDataToggle_i           in   1  configuration event: expected toggle := DATA0
//  rxPacketStart_i             in   1  1-cycle pulse: DATAx PID received
//  rxDataToggle_i              in   1  DATA1=1/DATA0=0, valid with rxPacketStart_i
//  rxDataValid_i               in   1  payload byte strobe (CRC bytes excluded)
//  rxData_i                    in   8  payload byte
//  rxPacketDone_i              in   1  1-cycle pulse: packet ended; never with rxDataValid_i
//  rxPacketOk_i                in   1  CRC16/bitstuff ok, valid with rxPacketDone_i
//  EP_OUT_full_i               in   1  FIFO cannot accept a byte
//  EP_OUT_dataValid_o          out  1  write strobe to FIFO
//  EP_OUT_data_o               out  8  write data
//  EP_OUT_fillTransDone_o      out  1  1-cycle pulse: end of fill transaction
//  EP_OUT_fillTransSuccess_o   out  1  commit(1)/rollback(0), valid with fillTransDone
//  respValid_o                 out  1  1-cycle pulse: handshake to send
//  respHandshakePID_o          out  1  1 with respValid_o
//  respPacketID_o              out  2  PID[3:2]: ACK=2'b00, NAK=2'b10
// BEHAVIOUR
//  - Reset: state IDLE, expected toggle 0, all outputs 0, flags/count/timer 0. Reset mid-packet: no fillTransDone issued.
//  - All outputs registered: write strobe/data 1 cycle after rxDataValid_i; fillTransDone_o and respValid_o
//    in the same cycle, 1 cycle after rxPacketDone_i (always after the last write strobe).
//  - States: IDLE, WAIT_DATA, RECEIVE, FINISH.
//    IDLE: gotTransStartPacket_i -> WAIT_DATA, timer := 0. rx* inputs ignored.
//    WAIT_DATA: rxPacketStart_i -> RECEIVE; latch dup := (toggle != expected) && !IS_ISOCHRONOUS,
//      nak := EP_OUT_full_i; count := 0. Repeated token restarts timer.
//    RECEIVE: per rxDataValid_i: write iff !dup && !nak && !babble && !EP_OUT_full_i && count < MAX_PACKET_SIZE.
//      Full seen on a byte to be written -> nak := 1. Byte at count == MAX_PACKET_SIZE -> babble := 1.
//      count saturates at MAX_PACKET_SIZE, width $clog2(MAX_PACKET_SIZE+1). rxPacketDone_i -> FINISH.
//    FINISH (1 cycle): fillTransDone_o=1; success = rxPacketOk && !dup && !nak && !babble. Response:
//      !rxPacketOk or babble -> none; nak -> NAK; dup -> ACK, no toggle change; else ACK, expected toggle flips.
//      IS_ISOCHRONOUS: never respond, toggle untouched. -> IDLE.
//  - Rollback with zero bytes written is legal (dup/nak-at-start still pulse fillTransDone, success=0).
//  - resetDataToggle_i: sync clear; wins over a simultaneous flip. Does not change state.
//  - gotTransStartPacket_i in RECEIVE/FINISH ignored.
// CONFIGURATION
//  USB_EP_OUT_FILL_TIMEOUT_EN defined: timer counts in WAIT_DATA; at TIMEOUT_CYCLES -> IDLE, no outputs.
//  Undefined: no timer; WAIT_DATA held until rxPacketStart_i; TIMEOUT_CYCLES unused.
// TESTING
//  1 token; DATA0 A1,B2,C3; ok -> 3 strobes A1,B2,C3; done+success=1; ACK 2'b00; next expect DATA1.
//  2 after 1, DATA0 again (5 bytes) -> no strobes; done, success=0; ACK; expected toggle stays 1.
//  3 full=1 at packet start, DATA0 4 bytes -> no strobes; success=0; NAK 2'b10; toggle unchanged.
//  4 full rises after 2 of 4 bytes -> 2 strobes; success=0; NAK.
//  5 DATA0 10 bytes, rxPacketOk=0 -> 10 strobes; success=0; no respValid. 65 bytes ok -> 64 strobes, success=0, none.
//  6 TIMEOUT_EN: token, idle 24 cycles -> IDLE; later DATA0 ignored. rst_i mid-RECEIVE -> outputs 0 next cycle.

Source files
------------

// File: rtl/usb_ep_out_fill_ctrl_if.sv
// Signal bundle around usb_ep_out_fill_ctrl: RX decoder inputs, endpoint FIFO fill port and handshake response.
// The master modport is the fill controller's view; slave is the environment's view.
interface usb_ep_out_fill_ctrl_if;
  logic       gotTransStartPacket_i;
  logic       resetDataToggle_i;
  logic       rxPacketStart_i;
  logic       rxDataToggle_i;
  logic       rxDataValid_i;
  logic [7:0] rxData_i;
  logic       rxPacketDone_i;
  logic       rxPacketOk_i;
  logic       EP_OUT_full_i;
  logic       EP_OUT_dataValid_o;
  logic [7:0] EP_OUT_data_o;
  logic       EP_OUT_fillTransDone_o;
  logic       EP_OUT_fillTransSuccess_o;
  logic       respValid_o;
  logic       respHandshakePID_o;
  logic [1:0] respPacketID_o;

  modport master (
    input  gotTransStartPacket_i, resetDataToggle_i, rxPacketStart_i, rxDataToggle_i,
    input  rxDataValid_i, rxData_i, rxPacketDone_i, rxPacketOk_i, EP_OUT_full_i,
    output EP_OUT_dataValid_o, EP_OUT_data_o, EP_OUT_fillTransDone_o, EP_OUT_fillTransSuccess_o,
    output respValid_o, respHandshakePID_o, respPacketID_o
  );

  modport slave (
    output gotTransStartPacket_i, resetDataToggle_i, rxPacketStart_i, rxDataToggle_i,
    output rxDataValid_i, rxData_i, rxPacketDone_i, rxPacketOk_i, EP_OUT_full_i,
    input  EP_OUT_dataValid_o, EP_OUT_data_o, EP_OUT_fillTransDone_o, EP_OUT_fillTransSuccess_o,
    input  respValid_o, respHandshakePID_o, respPacketID_o
  );
endinterface

// File: rtl/usb_ep_out_fill_ctrl.sv
// OUT endpoint fill controller: toggle check, FIFO-full/babble detection, commit/rollback and ACK/NAK response.
// Optional token-to-data timeout is enabled by defining USB_EP_OUT_FILL_TIMEOUT_EN.
module usb_ep_out_fill_ctrl #(
  parameter int unsigned MAX_PACKET_SIZE = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 24,
  parameter bit          IS_ISOCHRONOUS  = 1'b0
) (
  input  logic                   clk12_i,
  input  logic                   rst_i,
  usb_ep_out_fill_ctrl_if.master ep_if
);

  localparam int unsigned      CNT_W   = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PACKET_SIZE);
  localparam logic [1:0]       PID_ACK = 2'b00;
  localparam logic [1:0]       PID_NAK = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_RECEIVE   = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             toggle_q, toggle_d;
  logic             dup_q, dup_d;
  logic             nak_q, nak_d;
  logic             babble_q, babble_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             success_q, success_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_pid_q, resp_pid_d;
  logic             toggle_flip_s;
  logic             accept_s;
  logic             timeout_s;

  // A byte is eligible for the FIFO only while the packet is still clean and within size.
  assign accept_s = !dup_q && !nak_q && !babble_q && (count_q < MAX_CNT);

`ifdef USB_EP_OUT_FILL_TIMEOUT_EN
  localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 32'd1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Timer runs only while waiting for DATAx; a repeated token restarts it.
  always_comb begin
    timer_d   = '0;
    timeout_s = 1'b0;
    if ((state_q == ST_WAIT_DATA) && !ep_if.gotTransStartPacket_i) begin
      timer_d   = timer_q + TMR_W'(1);
      timeout_s = !ep_if.rxPacketStart_i && (timer_q == TMR_LAST);
    end else begin
      timer_d   = '0;
      timeout_s = 1'b0;
    end
  end

  // Timer register.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 32'd0);
  assign timeout_s        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ep_if.gotTransStartPacket_i) state_d = ST_WAIT_DATA;
        else                             state_d = ST_IDLE;
      end
      ST_WAIT_DATA: begin
        if (ep_if.rxPacketStart_i) state_d = ST_RECEIVE;
        else if (timeout_s)        state_d = ST_IDLE;
        else                       state_d = ST_WAIT_DATA;
      end
      ST_RECEIVE: begin
        if (ep_if.rxPacketDone_i) state_d = ST_FINISH;
        else                      state_d = ST_RECEIVE;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and packet-flag next values; outputs are registered so they lag their cause by one cycle.
  always_comb begin
    dup_d         = dup_q;
    nak_d         = nak_q;
    babble_d      = babble_q;
    count_d       = count_q;
    wr_valid_d    = 1'b0;
    wr_data_d     = wr_data_q;
    done_d        = 1'b0;
    success_d     = 1'b0;
    resp_valid_d  = 1'b0;
    resp_pid_d    = 2'b00;
    toggle_flip_s = 1'b0;
    case (state_q)
      ST_WAIT_DATA: begin
        if (ep_if.rxPacketStart_i) begin
          dup_d    = (ep_if.rxDataToggle_i != toggle_q) && !IS_ISOCHRONOUS;
          nak_d    = ep_if.EP_OUT_full_i;
          babble_d = 1'b0;
          count_d  = '0;
        end else begin
          count_d = count_q;
        end
      end
      ST_RECEIVE: begin
        if (ep_if.rxDataValid_i) begin
          if (accept_s && !ep_if.EP_OUT_full_i) begin
            wr_valid_d = 1'b1;
            wr_data_d  = ep_if.rxData_i;
          end else if (accept_s) begin
            nak_d = 1'b1;
          end else begin
            nak_d = nak_q;
          end
          if (count_q == MAX_CNT) babble_d = 1'b1;
          else                    count_d  = count_q + CNT_W'(1);
        end else if (ep_if.rxPacketDone_i) begin
          done_d    = 1'b1;
          success_d = ep_if.rxPacketOk_i && !dup_q && !nak_q && !babble_q;
          // Corrupt or babbling packets get no handshake at all.
          if (!IS_ISOCHRONOUS && ep_if.rxPacketOk_i && !babble_q) begin
            resp_valid_d = 1'b1;
            if (nak_q) begin
              resp_pid_d = PID_NAK;
            end else begin
              resp_pid_d    = PID_ACK;
              toggle_flip_s = !dup_q;
            end
          end else begin
            resp_valid_d = 1'b0;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        wr_valid_d = 1'b0;
      end
    endcase

    if (ep_if.resetDataToggle_i) toggle_d = 1'b0;
    else if (toggle_flip_s)      toggle_d = ~toggle_q;
    else                         toggle_d = toggle_q;
  end

  // Packet flags, expected toggle and output registers.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      toggle_q     <= 1'b0;
      dup_q        <= 1'b0;
      nak_q        <= 1'b0;
      babble_q     <= 1'b0;
      count_q      <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= 8'h00;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pid_q   <= 2'b00;
    end else begin
      toggle_q     <= toggle_d;
      dup_q        <= dup_d;
      nak_q        <= nak_d;
      babble_q     <= babble_d;
      count_q      <= count_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      success_q    <= success_d;
      resp_valid_q <= resp_valid_d;
      resp_pid_q   <= resp_pid_d;
    end
  end

  assign ep_if.EP_OUT_dataValid_o        = wr_valid_q;
  assign ep_if.EP_OUT_data_o             = wr_data_q;
  assign ep_if.EP_OUT_fillTransDone_o    = done_q;
  assign ep_if.EP_OUT_fillTransSuccess_o = success_q;
  assign ep_if.respValid_o               = resp_valid_q;
  assign ep_if.respHandshakePID_o        = resp_valid_q;
  assign ep_if.respPacketID_o            = resp_pid_q;

endmodule

// File: tb/tb_usb_ep_out_fill_ctrl.sv
// Self-checking bench for usb_ep_out_fill_ctrl: directed scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_usb_ep_out_fill_ctrl;
  localparam int MPS = 64;

  logic clk12 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk12 = ~clk12;

  usb_ep_out_fill_ctrl_if ep_if();

  usb_ep_out_fill_ctrl #(
    .MAX_PACKET_SIZE(MPS),
    .TIMEOUT_CYCLES (24),
    .IS_ISOCHRONOUS (1'b0)
  ) dut (
    .clk12_i(clk12),
    .rst_i  (rst),
    .ep_if  (ep_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk12) cyc <= cyc + 1;

  // Output collector (written only here).
  logic [7:0] got_q[$];
  int         done_cnt = 0, resp_cnt = 0, done_cyc = 0, resp_cyc = 0;
  logic       last_success = 1'b0, last_hs = 1'b0;
  logic [1:0] last_pid = 2'b00;

  always @(negedge clk12) begin
    if (ep_if.EP_OUT_dataValid_o === 1'b1) got_q.push_back(ep_if.EP_OUT_data_o);
    if (ep_if.EP_OUT_fillTransDone_o === 1'b1) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      last_success <= ep_if.EP_OUT_fillTransSuccess_o;
    end
    if (ep_if.respValid_o === 1'b1) begin
      resp_cnt <= resp_cnt + 1;
      resp_cyc <= cyc;
      last_hs  <= ep_if.respHandshakePID_o;
      last_pid <= ep_if.respPacketID_o;
    end
  end

  // Packet under test and reference model state.
  logic [7:0] pkt_data[0:127];
  bit         pkt_full[0:127];
  int         pkt_len;
  bit         exp_tog = 1'b0;
  logic [7:0] exp_bytes[$];
  bit         exp_success;
  int         exp_resp;          // 0 none, 1 ACK, 2 NAK
  int         base_strobes, base_done, base_resp, done_drive_cyc;

  task automatic model_packet(input bit tog, input bit full_start, input bit ok, input bit rst_tog);
    bit dup, nak, babble;
    exp_bytes.delete();
    dup    = (tog != exp_tog);
    nak    = full_start;
    babble = (pkt_len > MPS);
    for (int i = 0; i < pkt_len && i < MPS; i++) begin
      if (!dup && !nak) begin
        if (pkt_full[i]) nak = 1'b1;
        else             exp_bytes.push_back(pkt_data[i]);
      end
    end
    exp_success = ok && !dup && !nak && !babble;
    if (!ok || babble) exp_resp = 0;
    else if (nak)      exp_resp = 2;
    else begin
      exp_resp = 1;
      if (!dup) exp_tog = ~exp_tog;
    end
    if (rst_tog) exp_tog = 1'b0;
  endtask

  task automatic fill_random(input int len, input int full_odds);
    pkt_len = len;
    for (int i = 0; i < len; i++) begin
      pkt_data[i] = 8'($urandom);
      pkt_full[i] = (full_odds > 0) && ($urandom_range(0, full_odds) == 0);
    end
  endtask

  task automatic mark_bases();
    base_strobes = got_q.size();
    base_done    = done_cnt;
    base_resp    = resp_cnt;
  endtask

  task automatic send_token();
    @(negedge clk12);
    ep_if.gotTransStartPacket_i = 1'b1;
    @(negedge clk12);
    ep_if.gotTransStartPacket_i = 1'b0;
  endtask

  task automatic drive_packet(input bit tog, input bit full_start, input bit ok, input bit rst_tog);
    int gaps;
    @(negedge clk12);
    ep_if.rxPacketStart_i = 1'b1;
    ep_if.rxDataToggle_i  = tog;
    ep_if.EP_OUT_full_i   = full_start;
    @(negedge clk12);
    ep_if.rxPacketStart_i = 1'b0;
    ep_if.rxDataToggle_i  = 1'b0;
    for (int i = 0; i < pkt_len; i++) begin
      gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        ep_if.rxDataValid_i = 1'b0;
        ep_if.EP_OUT_full_i = 1'($urandom_range(0, 1));
        @(negedge clk12);
      end
      ep_if.rxDataValid_i = 1'b1;
      ep_if.rxData_i      = pkt_data[i];
      ep_if.EP_OUT_full_i = pkt_full[i];
      @(negedge clk12);
    end
    ep_if.rxDataValid_i     = 1'b0;
    ep_if.EP_OUT_full_i     = 1'b0;
    ep_if.rxPacketDone_i    = 1'b1;
    ep_if.rxPacketOk_i      = ok;
    ep_if.resetDataToggle_i = rst_tog;
    done_drive_cyc          = cyc;
    @(negedge clk12);
    ep_if.rxPacketDone_i    = 1'b0;
    ep_if.rxPacketOk_i      = 1'b0;
    ep_if.resetDataToggle_i = 1'b0;
  endtask

  // Full OUT transaction: token, packet, then comparison of everything observed against the model.
  task automatic run_transaction(input string name, input bit tog, input bit full_start,
                                 input bit ok, input bit rst_tog);
    int n;
    mark_bases();
    model_packet(tog, full_start, ok, rst_tog);
    send_token();
    drive_packet(tog, full_start, ok, rst_tog);
    repeat (3) @(negedge clk12);
    n = got_q.size() - base_strobes;
    n_checks++;
    if (n !== exp_bytes.size()) begin
      n_fail++;
      $display("FAIL %s strobe_count: got %0d expected %0d", name, n, exp_bytes.size());
    end
    for (int i = 0; i < n && i < exp_bytes.size(); i++) begin
      n_checks++;
      if (got_q[base_strobes + i] !== exp_bytes[i]) begin
        n_fail++;
        $display("FAIL %s data[%0d]: got %02h expected %02h", name, i, got_q[base_strobes + i], exp_bytes[i]);
      end
    end
    n_checks++;
    if (done_cnt - base_done !== 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt - base_done);
    end
    n_checks++;
    if (done_cyc !== done_drive_cyc + 1) begin
      n_fail++;
      $display("FAIL %s done_latency: got cycle %0d expected %0d", name, done_cyc, done_drive_cyc + 1);
    end
    n_checks++;
    if (last_success !== exp_success) begin
      n_fail++;
      $display("FAIL %s success: got %0b expected %0b", name, last_success, exp_success);
    end
    n_checks++;
    if (resp_cnt - base_resp !== ((exp_resp != 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s resp_count: got %0d expected %0d", name, resp_cnt - base_resp, (exp_resp != 0) ? 1 : 0);
    end
    if (exp_resp != 0 && resp_cnt - base_resp == 1) begin
      n_checks++;
      if (last_pid !== ((exp_resp == 2) ? 2'b10 : 2'b00) || last_hs !== 1'b1) begin
        n_fail++;
        $display("FAIL %s resp_pid: got pid %02b hs %0b expected pid %02b hs 1", name, last_pid, last_hs,
                 (exp_resp == 2) ? 2'b10 : 2'b00);
      end
      n_checks++;
      if (resp_cyc !== done_cyc) begin
        n_fail++;
        $display("FAIL %s resp_align: got cycle %0d expected %0d", name, resp_cyc, done_cyc);
      end
    end
  endtask

  // Packet without an accepted token must leave no trace on any output.
  task automatic expect_ignored(input string name, input bit tog);
    mark_bases();
    fill_random(4, 0);
    drive_packet(tog, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk12);
    n_checks++;
    if (got_q.size() != base_strobes || done_cnt != base_done || resp_cnt != base_resp) begin
      n_fail++;
      $display("FAIL %s ignored: got strobes %0d done %0d resp %0d expected 0 0 0", name,
               got_q.size() - base_strobes, done_cnt - base_done, resp_cnt - base_resp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk12);
    n_checks++;
    if ({ep_if.EP_OUT_dataValid_o, ep_if.EP_OUT_data_o, ep_if.EP_OUT_fillTransDone_o,
         ep_if.EP_OUT_fillTransSuccess_o, ep_if.respValid_o, ep_if.respHandshakePID_o,
         ep_if.respPacketID_o} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dv=%b data=%h done=%b succ=%b rv=%b hs=%b pid=%b expected all 0",
               ep_if.EP_OUT_dataValid_o, ep_if.EP_OUT_data_o, ep_if.EP_OUT_fillTransDone_o,
               ep_if.EP_OUT_fillTransSuccess_o, ep_if.respValid_o, ep_if.respHandshakePID_o,
               ep_if.respPacketID_o);
    end
    rst = 1'b0;
    exp_tog = 1'b0;
    repeat (2) @(negedge clk12);
    n_checks++;
    if (ep_if.EP_OUT_fillTransDone_o !== 1'b0 || ep_if.respValid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got done=%b rv=%b expected 0 0", ep_if.EP_OUT_fillTransDone_o, ep_if.respValid_o);
    end
  endtask

  task automatic test_basic_ack();
    pkt_len = 3;
    pkt_data[0] = 8'hA1; pkt_data[1] = 8'hB2; pkt_data[2] = 8'hC3;
    for (int i = 0; i < 3; i++) pkt_full[i] = 1'b0;
    run_transaction("basic_ack", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_duplicate();
    fill_random(5, 0);
    run_transaction("duplicate", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_nak();
    fill_random(4, 0);
    run_transaction("nak_at_start", 1'b0, 1'b1, 1'b1, 1'b0);
    fill_random(4, 0);
    pkt_full[2] = 1'b1; pkt_full[3] = 1'b1;
    run_transaction("nak_mid_packet", exp_tog, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_bad_crc_and_babble();
    fill_random(10, 0);
    run_transaction("bad_crc", exp_tog, 1'b0, 1'b0, 1'b0);
    fill_random(65, 0);
    run_transaction("babble_65", exp_tog, 1'b0, 1'b1, 1'b0);
    fill_random(64, 0);
    run_transaction("max_size_64", exp_tog, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_toggle_reset();
    if (exp_tog == 1'b0) begin
      fill_random(2, 0);
      run_transaction("toggle_prep", 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      exp_tog = exp_tog;
    end
    @(negedge clk12);
    ep_if.resetDataToggle_i = 1'b1;
    @(negedge clk12);
    ep_if.resetDataToggle_i = 1'b0;
    exp_tog = 1'b0;
    fill_random(3, 0);
    run_transaction("after_toggle_reset", 1'b0, 1'b0, 1'b1, 1'b1);
    fill_random(2, 0);
    run_transaction("toggle_reset_wins", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_idle_ignored();
    expect_ignored("no_token", exp_tog);
  endtask

  task automatic test_wait_data();
`ifdef USB_EP_OUT_FILL_TIMEOUT_EN
    send_token();
    repeat (30) @(negedge clk12);
    expect_ignored("timeout_to_idle", exp_tog);
    mark_bases();
    fill_random(3, 0);
    model_packet(exp_tog, 1'b0, 1'b1, 1'b0);
    send_token();
    repeat (18) @(negedge clk12);
    drive_packet(~exp_tog, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk12);
    n_checks++;
    if (got_q.size() - base_strobes !== exp_bytes.size() || done_cnt - base_done !== 1) begin
      n_fail++;
      $display("FAIL before_timeout: got strobes %0d done %0d expected %0d 1",
               got_q.size() - base_strobes, done_cnt - base_done, exp_bytes.size());
    end
`else
    mark_bases();
    fill_random(3, 0);
    model_packet(exp_tog, 1'b0, 1'b1, 1'b0);
    send_token();
    repeat (40) @(negedge clk12);
    drive_packet(~exp_tog, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk12);
    n_checks++;
    if (got_q.size() - base_strobes !== exp_bytes.size() || done_cnt - base_done !== 1) begin
      n_fail++;
      $display("FAIL wait_hold: got strobes %0d done %0d expected %0d 1",
               got_q.size() - base_strobes, done_cnt - base_done, exp_bytes.size());
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    mark_bases();
    send_token();
    @(negedge clk12);
    ep_if.rxPacketStart_i = 1'b1;
    ep_if.rxDataToggle_i  = exp_tog;
    @(negedge clk12);
    ep_if.rxPacketStart_i = 1'b0;
    ep_if.rxDataValid_i   = 1'b1;
    ep_if.rxData_i        = 8'h5A;
    @(negedge clk12);
    ep_if.rxData_i        = 8'h6B;
    rst                   = 1'b1;
    ep_if.rxDataValid_i   = 1'b0;
    @(negedge clk12);
    n_checks++;
    if (ep_if.EP_OUT_dataValid_o !== 1'b0 || ep_if.EP_OUT_fillTransDone_o !== 1'b0 || ep_if.respValid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got dv=%b done=%b rv=%b expected 0 0 0",
               ep_if.EP_OUT_dataValid_o, ep_if.EP_OUT_fillTransDone_o, ep_if.respValid_o);
    end
    rst     = 1'b0;
    exp_tog = 1'b0;
    repeat (3) @(negedge clk12);
    n_checks++;
    if (done_cnt != base_done) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", done_cnt - base_done);
    end
    expect_ignored("reset_mid_idle", 1'b0);
    fill_random(2, 0);
    run_transaction("reset_mid_recover", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit tog, fs, ok;
    int len;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk12);
        ep_if.resetDataToggle_i = 1'b1;
        @(negedge clk12);
        ep_if.resetDataToggle_i = 1'b0;
        exp_tog = 1'b0;
      end else begin
        exp_tog = exp_tog;
      end
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 12));
      tog = ($urandom_range(0, 3) == 0) ? ~exp_tog : exp_tog;
      fs  = ($urandom_range(0, 9) == 0);
      ok  = ($urandom_range(0, 5) != 0);
      fill_random(len, ($urandom_range(0, 1) == 1) ? 12 : 0);
      run_transaction($sformatf("random_%0d", k), tog, fs, ok, 1'b0);
    end
  endtask

  initial begin
    ep_if.gotTransStartPacket_i = 1'b0;
    ep_if.resetDataToggle_i     = 1'b0;
    ep_if.rxPacketStart_i       = 1'b0;
    ep_if.rxDataToggle_i        = 1'b0;
    ep_if.rxDataValid_i         = 1'b0;
    ep_if.rxData_i              = 8'h00;
    ep_if.rxPacketDone_i        = 1'b0;
    ep_if.rxPacketOk_i          = 1'b0;
    ep_if.EP_OUT_full_i         = 1'b0;
    test_reset();
    test_basic_ack();
    test_duplicate();
    test_nak();
    test_bad_crc_and_babble();
    test_toggle_reset();
    test_idle_ignored();
    test_wait_data();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d checks done, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
